// File: rtl/switch_flow_monitor_pkg.sv
// Shared types for the switch flow monitor.
// Error codes, capture FSM states and defaults.
package switch_flow_monitor_pkg;

    typedef enum logic [2:0] {
        COUNT_MISMATCH = 3'd0,
        OVERFLOW       = 3'd1,
        UNDERFLOW      = 3'd2,
        FLAG_MISMATCH  = 3'd3,
        GRANT_MULTI    = 3'd4,
        GRANT_NO_REQ   = 3'd5,
        STARVATION     = 3'd6
    } err_code_e;

    localparam int NUM_ERR      = 7;
    localparam int MON_MAX_WAIT = 16;

    typedef enum logic {
        CAP_IDLE,
        CAP_CAPTURED
    } cap_state_e;

endpackage

// File: rtl/switch_flow_monitor_if.sv
// Observed switch signals: per-port FIFO status
// and arbiter request/grant vectors.
interface switch_flow_monitor_if #(
    parameter int NUM_PORTS = 4,
    parameter int CNT_W     = 4
);
    logic [NUM_PORTS-1:0]       push;
    logic [NUM_PORTS-1:0]       pop;
    logic [NUM_PORTS*CNT_W-1:0] fifo_count;
    logic [NUM_PORTS-1:0]       fifo_empty;
    logic [NUM_PORTS-1:0]       fifo_full;
    logic [NUM_PORTS-1:0]       req;
    logic [NUM_PORTS-1:0]       grant;

    modport master (
        output push, pop, fifo_count,
        output fifo_empty, fifo_full,
        output req, grant
    );

    modport slave (
        input push, pop, fifo_count,
        input fifo_empty, fifo_full,
        input req, grant
    );
endinterface

// File: rtl/switch_flow_monitor_tracker.sv
// Per-port tracker: shadow occupancy, starvation
// counter, high-water mark and local error bits.
module flow_port_tracker
    import switch_flow_monitor_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int CNT_W    = 4,
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [CNT_W-1:0]   count,
    input  logic               empty,
    input  logic               full,
    input  logic               req,
    input  logic               grant,
    output logic [NUM_ERR-1:0] err,
    output logic [CNT_W-1:0]   high_water
);

    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] MAX_C   = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] LAST_C  = WAIT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0]  s_q;
    logic [CNT_W-1:0]  s_d;
    logic [CNT_W-1:0]  hw_q;
    logic [WAIT_W-1:0] w_q;
    logic [WAIT_W-1:0] w_d;
    logic              ovf;
    logic              unf;
    logic              starve;
    logic              cnt_mm;
    logic              flag_mm;
    logic              no_req;

    // Next shadow occupancy; blocked pushes/pops leave it unchanged.
    always_comb begin
        s_d = s_q;
        ovf = 1'b0;
        unf = 1'b0;
        unique case ({push, pop})
            2'b10: begin
                if (s_q == DEPTH_C) ovf = 1'b1;
                else                s_d = s_q + 1'b1;
            end
            2'b01: begin
                if (s_q == '0) unf = 1'b1;
                else           s_d = s_q - 1'b1;
            end
            2'b11: begin
                if (s_q == '0) begin
                    unf = 1'b1;
                    s_d = s_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Wait counter saturates; starvation fires only on the reaching step.
    always_comb begin
        w_d    = '0;
        starve = 1'b0;
        if (req && !grant) begin
            w_d    = (w_q == MAX_C) ? w_q : w_q + 1'b1;
            starve = (w_q == LAST_C);
        end
    end

    // Consistency of the observed FIFO against the shadow model.
    always_comb begin
        cnt_mm  = (count != s_q);
        flag_mm = (empty != (s_q == '0)) || (full != (s_q == DEPTH_C));
        no_req  = grant && !req;
    end

    assign err = {starve, no_req, 1'b0, flag_mm, unf, ovf, cnt_mm};
    assign high_water = hw_q;

    // Shadow count, wait counter and peak occupancy state.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q  <= '0;
            w_q  <= '0;
            hw_q <= '0;
        end else begin
            s_q <= s_d;
            w_q <= w_d;
            if (s_d > hw_q) hw_q <= s_d;
        end
    end

endmodule

// File: rtl/switch_flow_monitor.sv
// Switch flow monitor top: grant-vector checks,
// sticky error flags and first-error capture.
module switch_flow_monitor
    import switch_flow_monitor_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = $clog2(DEPTH + 1),
    parameter int MAX_WAIT  = MON_MAX_WAIT,
    parameter int WAIT_W    = $clog2(MAX_WAIT + 1),
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                         clk,
    input  logic                         rst,
    switch_flow_monitor_if.slave         mon,
    input  logic                         clr_err,
    output logic [NUM_PORTS*NUM_ERR-1:0] err_vec,
    output logic                         err_any,
    output logic                         first_valid,
    output logic [PORT_W-1:0]            first_port,
    output logic [2:0]                   first_code,
    output logic [NUM_PORTS*CNT_W-1:0]   high_water
);

    localparam int ERR_BITS = NUM_PORTS * NUM_ERR;

    logic [ERR_BITS-1:0] trk_err;
    logic [ERR_BITS-1:0] err_now;
    logic [ERR_BITS-1:0] err_q;
    logic                new_any;
    logic [PORT_W-1:0]   cap_port;
    logic [2:0]          cap_code;
    logic                load;
    cap_state_e          state_q;
    cap_state_e          state_d;
    logic [PORT_W-1:0]   port_q;
    logic [2:0]          code_q;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_trk
        flow_port_tracker #(
            .DEPTH    (DEPTH),
            .CNT_W    (CNT_W),
            .MAX_WAIT (MAX_WAIT),
            .WAIT_W   (WAIT_W)
        ) u_trk (
            .clk        (clk),
            .rst        (rst),
            .push       (mon.push[p]),
            .pop        (mon.pop[p]),
            .count      (mon.fifo_count[p*CNT_W +: CNT_W]),
            .empty      (mon.fifo_empty[p]),
            .full       (mon.fifo_full[p]),
            .req        (mon.req[p]),
            .grant      (mon.grant[p]),
            .err        (trk_err[p*NUM_ERR +: NUM_ERR]),
            .high_water (high_water[p*CNT_W +: CNT_W])
        );
    end

    // Merge per-port errors with the multi-grant check on the lowest grant.
    always_comb begin
        logic found;
        err_now = trk_err;
        found   = 1'b0;
        if ($countones(mon.grant) > 1) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (mon.grant[p] && !found) begin
                    err_now[p*NUM_ERR + int'(GRANT_MULTI)] = 1'b1;
                    found = 1'b1;
                end
            end
        end
    end

    // Lowest set bit wins: bit order is port-major, code-minor.
    always_comb begin
        new_any  = |err_now;
        cap_port = '0;
        cap_code = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            for (int c = NUM_ERR - 1; c >= 0; c--) begin
                if (err_now[p*NUM_ERR + c]) begin
                    cap_port = PORT_W'(p);
                    cap_code = 3'(c);
                end
            end
        end
    end

    // First-error FSM; a clear with a fresh error recaptures at once.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            CAP_IDLE: begin
                if (new_any) begin
                    state_d = CAP_CAPTURED;
                    load    = 1'b1;
                end
            end
            CAP_CAPTURED: begin
                if (clr_err) begin
                    state_d = new_any ? CAP_CAPTURED : CAP_IDLE;
                    load    = new_any;
                end
            end
            default: state_d = CAP_IDLE;
        endcase
    end

    // Capture state register and captured port/code.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CAP_IDLE;
            port_q  <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                port_q <= cap_port;
                code_q <= cap_code;
            end else if (state_d == CAP_IDLE) begin
                port_q <= '0;
                code_q <= '0;
            end
        end
    end

    // Sticky flags; new errors survive a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst)          err_q <= '0;
        else if (clr_err) err_q <= err_now;
        else              err_q <= err_q | err_now;
    end

    assign err_vec     = err_q;
    assign err_any     = |err_q;
    assign first_valid = (state_q == CAP_CAPTURED);
    assign first_port  = port_q;
    assign first_code  = code_q;

endmodule

// File: tb/tb_switch_flow_monitor.sv
// Directed bench for switch_flow_monitor with
// hand-computed expected flags and captures.
module tb_switch_flow_monitor;

    localparam int NP = 4;
    localparam int CW = 4;
    localparam int NE = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr_err;
    logic [NP*NE-1:0] err_vec;
    logic             err_any;
    logic             first_valid;
    logic [1:0]       first_port;
    logic [2:0]       first_code;
    logic [NP*CW-1:0] high_water;

    int checks   = 0;
    int failures = 0;

    switch_flow_monitor_if #(.NUM_PORTS(NP), .CNT_W(CW)) mif ();

    switch_flow_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .mon         (mif),
        .clr_err     (clr_err),
        .err_vec     (err_vec),
        .err_any     (err_any),
        .first_valid (first_valid),
        .first_port  (first_port),
        .first_code  (first_code),
        .high_water  (high_water)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cnt(input int p, input int v);
        mif.fifo_count[p*CW +: CW] = v[CW-1:0];
        mif.fifo_empty[p] = (v == 0);
        mif.fifo_full[p]  = (v == 8);
    endtask

    function automatic logic [63:0] eb(input int p, input int c);
        return 64'd1 << (p * NE + c);
    endfunction

    initial begin
        rst = 1'b1;
        clr_err = 1'b0;
        mif.push = '0;
        mif.pop = '0;
        mif.req = '0;
        mif.grant = '0;
        for (int p = 0; p < NP; p++) set_cnt(p, 0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst err_vec", 64'(err_vec), 64'd0);
        chk("rst first_valid", 64'(first_valid), 64'd0);
        chk("rst high_water", 64'(high_water), 64'd0);
        tick();
        chk("idle err_any", 64'(err_any), 64'd0);

        // 1: push x3 then pop x3 on port 0
        mif.push = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            set_cnt(0, i + 1);
        end
        mif.push = '0;
        mif.pop = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            set_cnt(0, 2 - i);
        end
        mif.pop = '0;
        tick();
        chk("t1 err_vec", 64'(err_vec), 64'd0);
        chk("t1 hw0", 64'(high_water[3:0]), 64'd3);
        chk("t1 hw rest", 64'(high_water[15:4]), 64'd0);
        tick();
        chk("t1 s0 zero", 64'(err_any), 64'd0);

        // 2: push x9 on port 1, count held at 8
        mif.push = 4'b0010;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) chk("t2 pre ovf", 64'(err_any), 64'd0);
            tick();
            set_cnt(1, (i + 1 > 8) ? 8 : i + 1);
        end
        mif.push = '0;
        chk("t2 err_vec", 64'(err_vec), eb(1, 1));
        chk("t2 first_valid", 64'(first_valid), 64'd1);
        chk("t2 first_port", 64'(first_port), 64'd1);
        chk("t2 first_code", 64'(first_code), 64'd1);
        chk("t2 hw1", 64'(high_water[7:4]), 64'd8);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t2 clr err_any", 64'(err_any), 64'd0);
        chk("t2 clr first", 64'(first_valid), 64'd0);

        // 3: underflow p2 together with count mismatch p3
        mif.push = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            tick();
            set_cnt(3, i + 1);
        end
        mif.push = '0;
        mif.pop = 4'b0100;
        mif.fifo_count[15:12] = 4'd5;
        tick();
        mif.pop = '0;
        set_cnt(3, 4);
        chk("t3 err_vec", 64'(err_vec), eb(2, 2) | eb(3, 0));
        chk("t3 first_port", 64'(first_port), 64'd2);
        chk("t3 first_code", 64'(first_code), 64'd2);
        chk("t3 hw3", 64'(high_water[15:12]), 64'd4);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t3 clr", 64'(err_any), 64'd0);

        // 4: two grants, one without request
        mif.req = 4'b0001;
        mif.grant = 4'b0101;
        tick();
        mif.req = '0;
        mif.grant = '0;
        chk("t4 err_vec", 64'(err_vec), eb(0, 4) | eb(2, 5));
        chk("t4 first_port", 64'(first_port), 64'd0);
        chk("t4 first_code", 64'(first_code), 64'd4);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t4 clr", 64'(err_any), 64'd0);

        // 5: starvation on p3, once, then re-armed by a grant
        mif.req = 4'b1000;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) chk("t5 w15", 64'(err_any), 64'd0);
        end
        chk("t5 starve", 64'(err_vec), eb(3, 6));
        chk("t5 first_port", 64'(first_port), 64'd3);
        chk("t5 first_code", 64'(first_code), 64'd6);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tick();
        tick();
        chk("t5 once", 64'(err_any), 64'd0);
        mif.grant = 4'b1000;
        tick();
        mif.grant = '0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) chk("t5 rearm w15", 64'(err_any), 64'd0);
        end
        chk("t5 rearm", 64'(err_vec), eb(3, 6));

        // 6: clear racing a new underflow, then reset mid-stream
        clr_err = 1'b1;
        mif.pop = 4'b0001;
        tick();
        clr_err = 1'b0;
        mif.pop = '0;
        chk("t6 err_vec", 64'(err_vec), eb(0, 2));
        chk("t6 first_valid", 64'(first_valid), 64'd1);
        chk("t6 first_port", 64'(first_port), 64'd0);
        chk("t6 first_code", 64'(first_code), 64'd2);
        mif.push = 4'b0011;
        tick();
        mif.push = '0;
        rst = 1'b1;
        tick();
        chk("t6 rst err_vec", 64'(err_vec), 64'd0);
        chk("t6 rst first", 64'(first_valid), 64'd0);
        chk("t6 rst code", 64'(first_code), 64'd0);
        chk("t6 rst hw", 64'(high_water), 64'd0);
        rst = 1'b0;
        mif.req = '0;
        for (int p = 0; p < NP; p++) set_cnt(p, 0);
        tick();
        chk("t6 post rst", 64'(err_any), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
